// File: rtl/nv_blkbox_pattern_src.sv
// nv_blkbox_pattern_src: burst source of constant/incrementing/LFSR words under pvld/prdy flow control.
// Optional LFSR generator is built only when NV_BLKBOX_SRC_LFSR_EN is defined; otherwise mode 2 acts as constant.
module nv_blkbox_pattern_src #(
    parameter int          DW        = 32,
    parameter int          LEN_W     = 8,
    parameter logic [31:0] SEED      = 32'h00000001,
    parameter logic [31:0] LFSR_TAPS = 32'h80200003
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             cfg_start,
    input  logic [1:0]       cfg_mode,
    input  logic [DW-1:0]    cfg_value,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             src_pvld,
    input  logic             src_prdy,
    output logic [DW-1:0]    src_pd,
    output logic             src_last,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_mode;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [DW-1:0]     r_data;
    logic              r_done;
    logic [DW-1:0]     w_data_nxt;
    logic [DW-1:0]     w_data_init;
    logic              w_accept;
    logic              w_end;
    assign w_accept = src_pvld & src_prdy;
    assign w_end    = (r_cnt == r_len);
    assign src_pvld = (r_state == RUN);
    assign busy     = (r_state == RUN);
    assign src_last = src_pvld & w_end;
    assign src_pd   = r_data;
    assign done     = r_done;
`ifdef NV_BLKBOX_SRC_LFSR_EN
    localparam logic [DW-1:0] L_TAPS = DW'(LFSR_TAPS);
    localparam logic [DW-1:0] L_SEED = DW'(SEED);
    logic [DW-1:0] w_lfsr;
    assign w_lfsr      = (r_data >> 1) ^ (r_data[0] ? L_TAPS : '0);
    assign w_data_nxt  = (r_mode == 2'd1) ? r_data + DW'(1) : (r_mode == 2'd2) ? w_lfsr : r_data;
    assign w_data_init = (cfg_mode == 2'd2 && cfg_value == '0) ? L_SEED : cfg_value;
`else
    logic w_unused_lfsr_params;
    assign w_unused_lfsr_params = ^{SEED, LFSR_TAPS};
    assign w_data_nxt  = (r_mode == 2'd1) ? r_data + DW'(1) : r_data;
    assign w_data_init = cfg_value;
`endif
    // State register
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) r_state <= IDLE;
        else                  r_state <= w_next;
    end
    // Next state: start only from IDLE, leave RUN when the last beat is accepted
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (cfg_start ? RUN : IDLE) : ((w_accept && w_end) ? IDLE : RUN);
    end
    // Burst capture, beat counting, data stepping and done pulse
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_mode <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_data <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_accept & w_end;
            if (r_state == IDLE && cfg_start) begin
                r_mode <= cfg_mode;
                r_len  <= cfg_len;
                r_cnt  <= '0;
                r_data <= w_data_init;
            end else if (w_accept && !w_end) begin
                r_cnt  <= r_cnt + LEN_W'(1);
                r_data <= w_data_nxt;
            end
        end
    end
endmodule
